// File: rtl/sha512_pkg.sv
// ---------------------------------------------------------------------------
// sha512_pkg
// Shared widths and the padder state encoding for the SHA-512 message padder.
//   SHA512_BLOCK_W : width of one SHA-512 compression block (1024 bits)
//   SHA512_HALF_W  : width of one output beat, half a block (512 bits)
//   LEN_FIELD_W    : width of the big-endian bit-length field (128 bits)
//   t_padder_state : IDLE (waiting for start), DATA (consuming message
//                    lines), PAD (emitting generated padding halves)
// ---------------------------------------------------------------------------
package sha512_pkg;

   localparam int SHA512_BLOCK_W = 1024;
   localparam int SHA512_HALF_W  = 512;
   localparam int LEN_FIELD_W    = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAD  = 2'd2
   } t_padder_state;

endpackage

// File: rtl/sha512_pad_line.sv
// ---------------------------------------------------------------------------
// sha512_pad_line
// Combinational padding of one 512-bit half of the padded message stream.
//   line     in  512    raw message bytes for this half, byte 0 at [511:504]
//   half_idx in  LEN_W+1 index of this half within the padded stream
//   msg_len  in  LEN_W  message length in bytes
//   padded   out 512    half with bytes past the message cleared, the 0x80
//                       terminator inserted and, on the final half, the
//                       128-bit big-endian bit length in the last 16 bytes
// ---------------------------------------------------------------------------
module sha512_pad_line
   import sha512_pkg::*;
#(
   parameter int LEN_W = 64
) (
   input  logic [SHA512_HALF_W-1:0] line,
   input  logic [LEN_W:0]           half_idx,
   input  logic [LEN_W-1:0]         msg_len,
   output logic [SHA512_HALF_W-1:0] padded
);

   localparam int CW = LEN_W + 1;
   // Byte offsets into the stream: half index times 64 plus byte position.
   localparam int OW = LEN_W + 7;

   logic [OW-1:0]          base;
   logic [OW-1:0]          off;
   logic [OW-1:0]          len_ext;
   logic [CW-1:0]          len_w;
   logic [CW-1:0]          halves;
   logic                   is_last;
   logic [LEN_FIELD_W-1:0] len_bits;

   always_comb begin
      len_w    = {1'b0, msg_len};
      // Message + 0x80 + 16-byte length, rounded up to whole 128-byte blocks.
      halves   = ((len_w + CW'(144)) >> 7) << 1;
      is_last  = (half_idx == halves - CW'(1));
      base     = {half_idx, 6'd0};
      len_ext  = OW'(msg_len);
      len_bits = LEN_FIELD_W'({msg_len, 3'b000});
      off      = '0;
      padded   = '0;
      for (int i = 0; i < 64; i++) begin
         off = base + OW'(i);
         if (off < len_ext) begin
            padded[511-8*i -: 8] = line[511-8*i -: 8];
         end else if (off == len_ext) begin
            padded[511-8*i -: 8] = 8'h80;
         end
      end
      // The half count guarantees the length field never overlaps message
      // bytes or the 0x80 terminator.
      if (is_last) begin
         padded[LEN_FIELD_W-1:0] = len_bits;
      end
   end

endmodule

// File: rtl/sha512_padder.sv
// ---------------------------------------------------------------------------
// sha512_padder
// Turns a byte-length message delivered as 512-bit lines into the padded
// SHA-512 stream, one 512-bit half block per beat, first half first.
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-low reset
//   start       in   one-cycle pulse starting a message (ignored while busy)
//   msg_len     in   message length in bytes, captured on start
//   line        in   message line, byte 0 at [511:504]
//   line_valid  in / line_ready out   upstream handshake
//   block       out  padded half block
//   block_valid out / ready in        downstream handshake
//   last        out  marks the final half of the final block
//   busy        out  message in progress
//   done        out  one-cycle pulse after the final transfer
//   fsm_state   out  current controller state (t_padder_state encoding)
//
// Both handshakes: a beat moves on a rising edge where valid and ready are
// both high. A valid source holds its data stable until that edge; ready
// may be raised or dropped at any time.
// ---------------------------------------------------------------------------
module sha512_padder
   import sha512_pkg::*;
#(
   parameter int LEN_W = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [LEN_W-1:0]         msg_len,
   input  logic [SHA512_HALF_W-1:0] line,
   input  logic                     line_valid,
   output logic                     line_ready,
   output logic [SHA512_HALF_W-1:0] block,
   output logic                     block_valid,
   input  logic                     ready,
   output logic                     last,
   output logic                     busy,
   output logic                     done,
   output logic [1:0]               fsm_state
);

   localparam int CW = LEN_W + 1;

   t_padder_state state_q, state_d;

   logic [LEN_W-1:0]         len_q;
   logic [CW-1:0]            halves_q;
   logic [CW-1:0]            lines_q;
   logic [CW-1:0]            load_cnt_q;   // halves written into the output register
   logic [CW-1:0]            xfer_cnt_q;   // halves accepted downstream
   logic [CW-1:0]            len_ext;
   logic [CW-1:0]            halves_calc;
   logic [CW-1:0]            lines_calc;
   logic                     out_free;
   logic                     xfer;
   logic                     final_xfer;
   logic                     line_take;
   logic                     pad_take;
   logic                     load;
   logic [SHA512_HALF_W-1:0] pad_in;
   logic [SHA512_HALF_W-1:0] pad_out;

   sha512_pad_line #(.LEN_W(LEN_W)) u_pad_line (
      .line     (pad_in),
      .half_idx (load_cnt_q),
      .msg_len  (len_q),
      .padded   (pad_out)
   );

   always_comb begin
      len_ext     = CW'(msg_len);
      halves_calc = ((len_ext + CW'(144)) >> 7) << 1;
      lines_calc  = (len_ext + CW'(63)) >> 6;

      out_free    = !block_valid || ready;
      xfer        = block_valid && ready;
      final_xfer  = xfer && (xfer_cnt_q == halves_q - CW'(1));
      line_ready  = (state_q == DATA) && out_free;
      line_take   = line_ready && line_valid;
      // When the final half is itself a message line, PAD only waits for it
      // to drain and generates nothing.
      pad_take    = (state_q == PAD) && out_free && (load_cnt_q < halves_q);
      load        = line_take || pad_take;
      pad_in      = line_take ? line : '0;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (msg_len == '0) ? PAD : DATA;
            end
         end
         DATA: begin
            if (line_take && (load_cnt_q == lines_q - CW'(1))) begin
               state_d = PAD;
            end
         end
         PAD: begin
            if (final_xfer) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         len_q       <= '0;
         halves_q    <= '0;
         lines_q     <= '0;
         load_cnt_q  <= '0;
         xfer_cnt_q  <= '0;
         block       <= '0;
         block_valid <= 1'b0;
         last        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q <= state_d;
         done    <= final_xfer;

         if ((state_q == IDLE) && start) begin
            len_q      <= msg_len;
            halves_q   <= halves_calc;
            lines_q    <= lines_calc;
            load_cnt_q <= '0;
            xfer_cnt_q <= '0;
         end

         if (load) begin
            block       <= pad_out;
            block_valid <= 1'b1;
            last        <= (load_cnt_q == halves_q - CW'(1));
            load_cnt_q  <= load_cnt_q + CW'(1);
         end else if (xfer) begin
            block_valid <= 1'b0;
            last        <= 1'b0;
         end

         if (xfer) begin
            xfer_cnt_q <= xfer_cnt_q + CW'(1);
         end
      end
   end

   assign busy      = (state_q != IDLE);
   assign fsm_state = state_q;

endmodule

// File: doc/sha512_padder.md
SHA512_PADDER -- requirements
Module: sha512_padder

Interface
REQ-001 SHALL have parameter: LEN_W, 64, width of message byte-length input.
REQ-002 SHALL have ports: clk  in  1  clock, all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle pulse, begins a message; ignored while busy.
REQ-005 msg_len  in  LEN_W  message length in bytes, captured on start.
REQ-006 line  in  512  message cache line; byte 0 at bits [511:504].
REQ-007 line_valid  in  1 / line_ready  out  1  upstream handshake; transfer when both high.
REQ-008 block  out  512  half of a 1024-bit SHA-512 block, first half first.
REQ-009 block_valid  out  1 / ready  in  1  downstream (sha512 core) handshake; transfer when both high.
REQ-010 last  out  1  high with final half of final block.
REQ-011 busy  out  1  message in progress; done  out  1  one-cycle pulse after final transfer.

Function
REQ-012 SHALL have states IDLE, DATA, PAD; IDLE->DATA on start if msg_len>0, IDLE->PAD on start if msg_len==0.
REQ-013 SHALL compute total halves H = 2*ceil((msg_len+17)/128) and data lines L = ceil(msg_len/64) at start.
REQ-014 In DATA, SHALL assert line_ready when output register empty or being drained (!block_valid || ready).
REQ-015 Each accepted line SHALL appear on block one cycle later with block_valid high; no combinational path line->block.
REQ-016 Bytes at stream offset >= msg_len within a line SHALL be forced to 0x00; byte at offset msg_len SHALL be 0x80.
REQ-017 After L lines accepted, DATA->PAD; PAD SHALL generate remaining halves internally without line_ready.
REQ-018 Final half's last 16 bytes SHALL carry msg_len*8 as 128-bit big-endian; bits above LEN_W+3 zero.
REQ-019 0x80 byte SHALL appear in a PAD half when msg_len is a multiple of 64 (byte 0 of first PAD half).
REQ-020 block and last SHALL hold stable while block_valid && !ready.
REQ-021 Half counter SHALL count transfers; on transfer of half H-1, last high, state->IDLE, done pulses next cycle, busy drops same cycle as done.
REQ-022 start in same cycle as done SHALL be accepted.
REQ-023 line_valid in IDLE or PAD SHALL be ignored (line_ready low).

Reset
REQ-024 On reset low, SHALL enter IDLE asynchronously; block=0, block_valid=0, last=0, line_ready=0, busy=0, done=0, counters=0.
REQ-025 Reset mid-message SHALL abort; no partial output after release.

Structure
REQ-026 sha512_pkg SHALL hold SHA512_BLOCK_W=1024, SHA512_HALF_W=512, t_padder_state enum, length-field width 128.
REQ-027 Combinational sub-module sha512_pad_line SHALL apply mask, 0x80 insertion and length field given line, half index, msg_len.
REQ-028 Output register and FSM SHALL reside in sha512_padder; total RTL 120-400 lines.

Verification
REQ-029 msg_len=3, line="abc"... -> half0=0x61626380 then zeros; half1 zeros ending 0x...0018; last on half1; 1 line consumed.
REQ-030 msg_len=0, start -> 2 halves, half0=0x80 then zeros, half1 all zero; line_ready never high; done pulse.
REQ-031 msg_len=112, 2 lines -> 4 halves; half1 byte 48=0x80; half3 ends 0x...0380.
REQ-032 msg_len=64, 1 line -> half0=line unmodified; half1 byte0=0x80, ends 0x...0200.
REQ-033 ready held low 5 cycles with block_valid high -> block/last stable, line_ready low; random ready stalls, end-to-end with sha512 core, "abc" -> digest ddaf35a1...a54ca49f.
REQ-034 reset asserted during PAD half -> all outputs 0 next edge; new start after release produces correct stream.
